// File: rtl/debounce_ctrl.sv
// debounce_ctrl: round-robin multi-channel debouncer that reports level changes as events.
// Optional macro DEBOUNCE_CTRL_EVFIFO_EN selects a 4-entry event FIFO instead of a single register.
module debounce_ctrl #(
    parameter int NCH = 8,
    parameter int CW  = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [NCH-1:0]         din,
    input  logic                   en,
    input  logic [CW-1:0]          thr,
    output logic [NCH-1:0]         dout,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [$clog2(NCH)-1:0] ev_ch,
    output logic                   ev_level,
    output logic                   ev_ovf,
    input  logic                   clr_ovf,
    output logic                   dbg_state
);
    localparam int CHW = $clog2(NCH);
    localparam int EW  = CHW + 1;
    localparam logic [CHW-1:0] LAST = CHW'(NCH - 1);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;
    state_t state, state_nxt;

    logic [NCH-1:0] sync1, sync2;
    logic [CW-1:0]  cnt [NCH];
    logic [CHW-1:0] ptr;
    logic           visit;
    logic           differ, accept, push, pop, push_ok, drop;
    logic [CW:0]    cnt_inc, thr_eff;
    logic [EW-1:0]  ev_data;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (en)  state_nxt = SCAN;
            SCAN: if (!en) state_nxt = IDLE;
        endcase
    end

    // A visit only happens while scanning with en still high; the cycle en drops starts the clear.
    always_comb begin
        visit     = (state == SCAN) && en;
        dbg_state = state;
    end

    // Counter math is one bit wider than cnt so a full counter never wraps to look "below" thr.
    always_comb begin
        differ  = sync2[ptr] ^ dout[ptr];
        cnt_inc = {1'b0, cnt[ptr]} + (CW+1)'(1);
        thr_eff = (thr == '0) ? (CW+1)'(1) : {1'b0, thr};
        accept  = visit && differ && (cnt_inc >= thr_eff);
        push    = accept;
        ev_data = {ptr, ~dout[ptr]};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else if (!visit) begin
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else if (!differ || accept) begin
            cnt[ptr] <= '0;
        end else begin
            cnt[ptr] <= cnt_inc[CW-1:0];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr  <= '0;
            dout <= '0;
        end else begin
            if (!visit)           ptr <= '0;
            else if (ptr == LAST) ptr <= '0;
            else                  ptr <= ptr + CHW'(1);
            if (accept) dout[ptr] <= ~dout[ptr];
        end
    end

    // Event handshake: an entry transfers on a rising edge where ev_valid and ev_ready are both
    // high; ev_ch/ev_level always show the oldest entry and cannot change until it transfers.
    // A push into a full queue succeeds only if the head leaves on the same edge.
`ifdef DEBOUNCE_CTRL_EVFIFO_EN
    logic [EW-1:0] mem [4];
    logic [1:0]    wr_idx, rd_idx;
    logic [2:0]    fill;

    always_comb begin
        ev_valid          = (fill != 3'd0);
        pop               = ev_valid && ev_ready;
        push_ok           = push && ((fill != 3'd4) || pop);
        drop              = push && (fill == 3'd4) && !pop;
        {ev_ch, ev_level} = mem[rd_idx];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_idx <= '0;
            rd_idx <= '0;
            fill   <= '0;
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_idx] <= ev_data;
                wr_idx      <= wr_idx + 2'd1;
            end
            if (pop) rd_idx <= rd_idx + 2'd1;
            case ({push_ok, pop})
                2'b10:   fill <= fill + 3'd1;
                2'b01:   fill <= fill - 3'd1;
                default: fill <= fill;
            endcase
        end
    end
`else
    logic          hold_v;
    logic [EW-1:0] hold_d;

    always_comb begin
        ev_valid          = hold_v;
        pop               = hold_v && ev_ready;
        push_ok           = push && (!hold_v || pop);
        drop              = push && hold_v && !pop;
        {ev_ch, ev_level} = hold_d;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hold_v <= 1'b0;
            hold_d <= '0;
        end else if (push_ok) begin
            hold_v <= 1'b1;
            hold_d <= ev_data;
        end else if (pop) begin
            hold_v <= 1'b0;
        end
    end
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)     ev_ovf <= 1'b0;
        else if (drop)    ev_ovf <= 1'b1;
        else if (clr_ovf) ev_ovf <= 1'b0;
    end

endmodule
